// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for pipeline stage registers.
// Contents:
//   pipe_state_t - occupancy state of a stage register (EMPTY, FULL, SKID).
//   STAT_W_DEF   - default width of the performance counters.
//   *_W          - payload widths packed by each instantiating stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    localparam int STAT_W_DEF = 16;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 148;
    localparam int EX_MEM_W = 107;
    localparam int MEM_WB_W = 71;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports:
//   clk   - rising-edge clock.
//   rst_n - asynchronous active-low reset; sets count to 0.
//   inc   - add one this cycle, unless the count is already all ones.
//   clr   - synchronous clear to 0; takes priority over inc.
//   count - current count value.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [STAT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with an optional skid entry, flush and stall counter.
// Ports:
//   clk       - rising-edge clock.
//   rst_n     - asynchronous active-low reset.
//   in_valid  - upstream payload valid.
//   in_ready  - stage accepts a payload this cycle.
//   in_data   - upstream payload.
//   out_valid - payload valid to downstream.
//   out_ready - downstream accepts the payload.
//   out_data  - payload to downstream; held stable while stalled.
//   flush     - drop every held entry and any simultaneous input; leave a bubble.
//   stat_clr  - synchronous clear of the stall counter.
//   stall_cnt - saturating count of cycles with out_valid & ~out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               SKID_EN    = 1,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter int               STAT_W     = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              flush,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stall_cnt
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             acc, rel;

    assign out_valid = state_q != EMPTY;
    assign out_data  = main_q;
    // With the skid entry, in_ready depends only on the state register, so
    // no combinational path runs from out_ready back to in_ready.
    assign in_ready  = SKID_EN != 0 ? state_q != SKID : (out_ready || !out_valid);
    assign acc       = in_valid && in_ready;
    assign rel       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (acc && rel) begin
                        main_d = in_data;
                    end else if (rel) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE_VAL;
                    end else if (acc && SKID_EN != 0) begin
                        state_d = SKID;
                        skid_d  = in_data;
                    end
                end
                SKID: begin
                    if (rel) begin
                        state_d = FULL;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    sat_counter #(.STAT_W(STAT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid && !out_ready),
        .clr   (stat_clr),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives a skid-buffered and a single-register stage with the same stimulus,
// comparing each against a queue-based model of held payloads.
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic       stat_clr = 1'b0;

    logic       in_ready1, out_valid1, in_ready0, out_valid0;
    logic [7:0] out_data1, out_data0;
    logic [3:0] stall_cnt1, stall_cnt0;

    int tests = 0;
    int fails = 0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];
    int         cnt1 = 0;
    int         cnt0 = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(8), .SKID_EN(1), .STAT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .flush(flush), .stat_clr(stat_clr), .stall_cnt(stall_cnt1)
    );

    pipe_stage_reg #(.WIDTH(8), .SKID_EN(0), .STAT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .flush(flush), .stat_clr(stat_clr), .stall_cnt(stall_cnt0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Skid stage holds up to two payloads and accepts whenever not full;
    // the plain stage holds one and accepts when empty or being drained.
    function automatic logic rdy_model(input int size, input logic skid, input logic ordy);
        return skid ? size < 2 : (ordy || size == 0);
    endfunction

    task automatic check_all();
        chk("d1 out_valid", 32'(out_valid1), 32'(q1.size() != 0));
        chk("d1 out_data", 32'(out_data1), 32'(q1.size() != 0 ? q1[0] : 8'h00));
        chk("d1 in_ready", 32'(in_ready1), 32'(rdy_model(q1.size(), 1'b1, out_ready)));
        chk("d1 stall_cnt", 32'(stall_cnt1), 32'(cnt1));
        chk("d0 out_valid", 32'(out_valid0), 32'(q0.size() != 0));
        chk("d0 out_data", 32'(out_data0), 32'(q0.size() != 0 ? q0[0] : 8'h00));
        chk("d0 in_ready", 32'(in_ready0), 32'(rdy_model(q0.size(), 1'b0, out_ready)));
        chk("d0 stall_cnt", 32'(stall_cnt0), 32'(cnt0));
    endtask

    // Apply one cycle of stimulus after a falling edge, check, then advance the model across the rising edge.
    task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                        input logic fl, input logic clr);
        logic acc1, rel1, acc0, rel0, st1, st0;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        stat_clr  = clr;
        #1;
        check_all();
        acc1 = iv && rdy_model(q1.size(), 1'b1, ordy);
        rel1 = q1.size() != 0 && ordy;
        st1  = q1.size() != 0 && !ordy;
        acc0 = iv && rdy_model(q0.size(), 1'b0, ordy);
        rel0 = q0.size() != 0 && ordy;
        st0  = q0.size() != 0 && !ordy;
        @(posedge clk);
        if (fl) q1.delete();
        else begin
            if (rel1) void'(q1.pop_front());
            if (acc1) q1.push_back(id);
        end
        if (fl) q0.delete();
        else begin
            if (rel0) void'(q0.pop_front());
            if (acc0) q0.push_back(id);
        end
        cnt1 = clr ? 0 : (st1 && cnt1 < 15 ? cnt1 + 1 : cnt1);
        cnt0 = clr ? 0 : (st0 && cnt0 < 15 ? cnt0 + 1 : cnt0);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        step(0, 8'h00, 1, 0, 0);
        // Streaming with downstream always ready.
        step(1, 8'h11, 1, 0, 0);
        step(1, 8'h22, 1, 0, 0);
        step(1, 8'h33, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // Fill the skid entry while stalled, then drain in order.
        step(1, 8'h0A, 0, 0, 0);
        step(1, 8'h0B, 0, 0, 0);
        step(1, 8'h0D, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // Flush while the skid entry is full and a new payload is offered.
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0);
        step(1, 8'h0C, 0, 1, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // Saturate the stall counter, then clear it.
        step(1, 8'h44, 0, 0, 0);
        for (int i = 0; i < 21; i++) step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        // out_ready toggling while holding data; the plain stage follows it combinationally.
        step(0, 8'h00, 1, 0, 0);
        step(1, 8'h55, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // Randomized traffic against the queue models.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
        // Asynchronous reset mid-operation drops everything immediately.
        step(1, 8'h66, 0, 0, 0);
        step(1, 8'h77, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        q1.delete();
        q0.delete();
        cnt1 = 0;
        cnt0 = 0;
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h88, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
